// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive packet block.
// Holds the packet FSM state enum, PID codes, CRC16 parameters,
// err_code bit positions and a PID check helper.
package usb_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned PID_W      = 4;
  localparam int unsigned CRC_W      = 16;
  localparam int unsigned ERR_W      = 3;
  localparam int unsigned BYTE_CNT_W = 11;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_CHECK,
    ST_ABORT
  } state_t;

  localparam logic [PID_W-1:0] PID_DATA0 = 4'h3;
  localparam logic [PID_W-1:0] PID_DATA1 = 4'hB;
  localparam logic [PID_W-1:0] PID_ACK   = 4'h2;

  // Reflected CRC16; the register lands on the residual after the CRC bytes.
  localparam logic [CRC_W-1:0] CRC16_POLY     = 16'hA001;
  localparam logic [CRC_W-1:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [CRC_W-1:0] CRC16_RESIDUAL = 16'hB001;

  localparam int unsigned ERR_PID_BIT   = 0;
  localparam int unsigned ERR_CRC_BIT   = 1;
  localparam int unsigned ERR_ABORT_BIT = 2;

  // Upper nibble of a PID byte must be the complement of the lower nibble.
  function automatic logic pid_check_ok(input logic [BYTE_W-1:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/usb_rx_pkt_if.sv
// Bus between the PHY-side receiver and the packet decoder.
// master: PHY side, drives rx_active/rx_valid/rx_data/rx_error.
// slave:  decoder, drives out_valid/out_data, pid, pkt_done, pkt_ok,
//         err_code, byte_cnt, good_cnt, bad_cnt.
interface usb_rx_pkt_if;
  import usb_pkg::*;

  logic                  rx_active;
  logic                  rx_valid;
  logic [BYTE_W-1:0]     rx_data;
  logic                  rx_error;
  logic                  out_valid;
  logic [BYTE_W-1:0]     out_data;
  logic [PID_W-1:0]      pid;
  logic                  pkt_done;
  logic                  pkt_ok;
  logic [ERR_W-1:0]      err_code;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [STAT_W-1:0]     good_cnt;
  logic [STAT_W-1:0]     bad_cnt;

  modport master (
    output rx_active, rx_valid, rx_data, rx_error,
    input  out_valid, out_data, pid, pkt_done, pkt_ok, err_code, byte_cnt,
           good_cnt, bad_cnt
  );

  modport slave (
    input  rx_active, rx_valid, rx_data, rx_error,
    output out_valid, out_data, pid, pkt_done, pkt_ok, err_code, byte_cnt,
           good_cnt, bad_cnt
  );

endinterface

// File: rtl/usb_crc16_byte.sv
// Combinational CRC16 update for one byte, LSB first, reflected polynomial.
// Ports: crc_in (current register), data (byte), crc_c (updated register).
module usb_crc16_byte
  import usb_pkg::*;
(
  input  logic [CRC_W-1:0]  crc_in,
  input  logic [BYTE_W-1:0] data,
  output logic [CRC_W-1:0]  crc_c
);

  // Eight serial shift steps, one per wire bit.
  always_comb begin
    crc_c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_c[0] ^ data[i]) crc_c = (crc_c >> 1) ^ CRC16_POLY;
      else                    crc_c = crc_c >> 1;
    end
  end

endmodule

// File: rtl/usb_rx_pkt.sv
// USB receive packet decoder: checks PID and CRC16, strips the two CRC
// bytes from the payload stream, reports per-packet status and statistics.
// Ports: clk, reset (sync, active high), bus (usb_rx_pkt_if.slave).
// Parameter MAX_BYTES: largest payload accepted before overflow.
// Macro USB_RX_STATS_EN: enables saturating good_cnt/bad_cnt counters;
// without it both read as constant 0.
module usb_rx_pkt
  import usb_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 1024
) (
  input logic         clk,
  input logic         reset,
  usb_rx_pkt_if.slave bus
);

  localparam int unsigned CNT_W = BYTE_CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES + 2);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

  state_t state_q, state_d;
  logic                  act_q;
  logic [CRC_W-1:0]      crc_q, crc_d, crc_step_c;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BYTE_W-1:0]     hold0_q, hold0_d, hold1_q, hold1_d;
  logic                  pid_err_q, pid_err_d;

  logic                  out_valid_q, out_valid_d;
  logic [BYTE_W-1:0]     out_data_q, out_data_d;
  logic [PID_W-1:0]      pid_q, pid_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  pkt_ok_q, pkt_ok_d;
  logic [ERR_W-1:0]      err_code_q, err_code_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  logic rising, fin, fin_abort, take_pid, crc_bad;

  usb_crc16_byte u_crc (
    .crc_in (crc_q),
    .data   (bus.rx_data),
    .crc_c  (crc_step_c)
  );

  // State and registered outputs. act_q resets high so a packet that is
  // already in flight at reset is skipped until rx_active drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      act_q       <= 1'b1;
      crc_q       <= CRC16_INIT;
      cnt_q       <= '0;
      hold0_q     <= '0;
      hold1_q     <= '0;
      pid_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pid_q       <= '0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      err_code_q  <= '0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= bus.rx_active;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      pid_err_q   <= pid_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pid_q       <= pid_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
      err_code_q  <= err_code_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  // Next state, datapath and output values.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    pid_err_d   = pid_err_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    pid_d       = pid_q;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = pkt_ok_q;
    err_code_d  = err_code_q;
    byte_cnt_d  = byte_cnt_q;
    fin         = 1'b0;
    fin_abort   = 1'b0;
    take_pid    = 1'b0;
    crc_bad     = 1'b0;
    rising      = bus.rx_active & ~act_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rising) begin
          crc_d     = CRC16_INIT;
          cnt_d     = '0;
          // A packet that never delivers a PID byte fails the PID check.
          pid_err_d = 1'b1;
          if (bus.rx_error)      state_d  = ST_ABORT;
          else if (bus.rx_valid) take_pid = 1'b1;
          else                   state_d  = ST_PID;
        end
      end
      ST_PID: begin
        if (!bus.rx_active) begin
          fin       = 1'b1;
          fin_abort = bus.rx_error;
        end else if (bus.rx_error) begin
          state_d = ST_ABORT;
        end else if (bus.rx_valid) begin
          take_pid = 1'b1;
        end
      end
      ST_DATA: begin
        if (!bus.rx_active) begin
          fin       = 1'b1;
          fin_abort = bus.rx_error;
        end else if (bus.rx_error) begin
          state_d = ST_ABORT;
        end else if (bus.rx_valid) begin
          if (cnt_q == CNT_MAX) begin
            state_d = ST_ABORT;
          end else begin
            crc_d   = crc_step_c;
            cnt_d   = cnt_q + CNT_W'(1);
            hold0_d = bus.rx_data;
            hold1_d = hold0_q;
            // Two bytes are always held back so the CRC never leaks out.
            if (cnt_q >= CNT_TWO) begin
              out_valid_d = 1'b1;
              out_data_d  = hold1_q;
            end
          end
        end
      end
      ST_CHECK: state_d = ST_IDLE;
      ST_ABORT: begin
        if (!bus.rx_active) begin
          fin       = 1'b1;
          fin_abort = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_pid) begin
      pid_d     = bus.rx_data[3:0];
      pid_err_d = ~pid_check_ok(bus.rx_data);
      state_d   = ST_DATA;
    end

    // Packet end: the CRC register is final since no byte is taken once
    // rx_active is low, so status is settled on the edge that enters CHECK.
    if (fin) begin
      state_d    = ST_CHECK;
      pkt_done_d = 1'b1;
      byte_cnt_d = (cnt_q >= CNT_TWO) ? BYTE_CNT_W'(cnt_q - CNT_TWO) : '0;
      crc_bad    = (crc_q != CRC16_RESIDUAL) || (cnt_q < CNT_TWO);
      err_code_d = '0;
      err_code_d[ERR_PID_BIT] = pid_err_q;
      if (fin_abort) err_code_d[ERR_ABORT_BIT] = 1'b1;
      else           err_code_d[ERR_CRC_BIT]   = crc_bad;
      pkt_ok_d   = ~|err_code_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.pid       = pid_q;
  assign bus.pkt_done  = pkt_done_q;
  assign bus.pkt_ok    = pkt_ok_q;
  assign bus.err_code  = err_code_q;
  assign bus.byte_cnt  = byte_cnt_q;

`ifdef USB_RX_STATS_EN
  logic [STAT_W-1:0] good_q, bad_q;

  // Saturating statistics, updated together with the pkt_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (pkt_done_d) begin
      if (pkt_ok_d) begin
        if (good_q != '1) good_q <= good_q + STAT_W'(1);
      end else begin
        if (bad_q != '1) bad_q <= bad_q + STAT_W'(1);
      end
    end
  end

  assign bus.good_cnt = good_q;
  assign bus.bad_cnt  = bad_q;
`else
  assign bus.good_cnt = '0;
  assign bus.bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_usb_rx_pkt.sv
// Scoreboard bench for usb_rx_pkt (MAX_BYTES=4): stimulus pushes expected
// payload bytes and packet results; a negedge monitor pops and compares.
module tb_usb_rx_pkt;
  import usb_pkg::*;

  typedef struct packed {
    logic        ok;
    logic [2:0]  err;
    logic [3:0]  pid;
    logic        cnt_vld;
    logic [10:0] cnt;
  } done_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  usb_rx_pkt_if bus ();

  usb_rx_pkt #(.MAX_BYTES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] dq[$];
  done_t      pq[$];
  logic [7:0] txq[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Monitor: every out_valid and pkt_done must match a queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) begin
        if (dq.size() == 0) begin
          checks++;
          $display("FAIL out_valid: unexpected byte %0h", bus.out_data);
        end else begin
          check("out_data", 32'(bus.out_data), 32'(dq.pop_front()));
        end
      end
      if (bus.pkt_done) begin
        if (pq.size() == 0) begin
          checks++;
          $display("FAIL pkt_done: unexpected, err_code %0b", bus.err_code);
        end else begin
          done_t e;
          e = pq.pop_front();
          check("pkt_ok", 32'(bus.pkt_ok), 32'(e.ok));
          check("err_code", 32'(bus.err_code), 32'(e.err));
          check("pid", 32'(bus.pid), 32'(e.pid));
          if (e.cnt_vld) check("byte_cnt", 32'(bus.byte_cnt), 32'(e.cnt));
        end
      end
    end
  end

  task automatic put_byte(input logic [7:0] b, input logic err);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.rx_error = err;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
  endtask

  // Sends txq as one packet; rx_error rides on byte index err_at.
  task automatic send(input int err_at);
    @(posedge clk); #1;
    bus.rx_active = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < txq.size(); i++) begin
      put_byte(txq[i], i == err_at);
      if (i == 1) begin
        @(posedge clk); #1;
      end
    end
    bus.rx_active = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("done_latency", 32'(pq.size()), 32'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input int good, input int bad);
`ifdef USB_RX_STATS_EN
    check("good_cnt", 32'(bus.good_cnt), 32'(good));
    check("bad_cnt", 32'(bus.bad_cnt), 32'(bad));
`else
    check("good_cnt", 32'(bus.good_cnt), 32'(0));
    check("bad_cnt", 32'(bus.bad_cnt), 32'(0));
    if (good < 0 || bad < 0) $display("negative stat expectation");
`endif
  endtask

  initial begin
    logic [15:0] c;
    bus.rx_active = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    bus.rx_error  = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_pkt_done", 32'(bus.pkt_done), 32'(0));
    check("rst_pkt_ok", 32'(bus.pkt_ok), 32'(0));
    check("rst_err_code", 32'(bus.err_code), 32'(0));
    check("rst_pid", 32'(bus.pid), 32'(0));
    check("rst_byte_cnt", 32'(bus.byte_cnt), 32'(0));
    check_stats(0, 0);

    // Zero-length DATA0.
    txq = '{8'hC3, 8'h00, 8'h00};
    pq.push_back('{1'b1, 3'b000, 4'h3, 1'b1, 11'd0});
    send(-1);

    // Corrupt CRC.
    txq = '{8'hC3, 8'h00, 8'h01};
    pq.push_back('{1'b0, 3'b010, 4'h3, 1'b1, 11'd0});
    send(-1);

    // Bad PID, CRC itself fine.
    txq = '{8'hC4, 8'h00, 8'h00};
    pq.push_back('{1'b0, 3'b001, 4'h4, 1'b1, 11'd0});
    send(-1);

    // DATA1 with four payload bytes and a valid CRC.
    c = 16'hFFFF;
    for (int i = 0; i < 4; i++) c = crc_upd(c, 8'(i));
    c = ~c;
    txq = '{8'h4B, 8'h00, 8'h01, 8'h02, 8'h03, c[7:0], c[15:8]};
    for (int i = 0; i < 4; i++) dq.push_back(8'(i));
    pq.push_back('{1'b1, 3'b000, 4'hB, 1'b1, 11'd4});
    send(-1);

    // Line error on the third payload byte: nothing forwarded.
    txq = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    pq.push_back('{1'b0, 3'b100, 4'h3, 1'b0, 11'd0});
    send(3);

    // Five-byte payload against MAX_BYTES=4: first four bytes escape.
    txq = '{8'hC3, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'hAA, 8'hBB};
    dq.push_back(8'h10); dq.push_back(8'h20);
    dq.push_back(8'h30); dq.push_back(8'h40);
    pq.push_back('{1'b0, 3'b100, 4'h3, 1'b0, 11'd0});
    send(-1);
    check_stats(2, 4);

    // Reset mid-packet: rest of that packet must be dropped silently.
    @(posedge clk); #1;
    bus.rx_active = 1'b1;
    @(posedge clk); #1;
    put_byte(8'hC3, 1'b0);
    put_byte(8'h11, 1'b0);
    put_byte(8'h22, 1'b0);
    reset = 1'b1;
    put_byte(8'h33, 1'b0);
    reset = 1'b0;
    put_byte(8'h44, 1'b0);
    put_byte(8'h55, 1'b0);
    put_byte(8'h66, 1'b0);
    bus.rx_active = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_rst_pid", 32'(bus.pid), 32'(0));
    check("mid_rst_byte_cnt", 32'(bus.byte_cnt), 32'(0));
    check_stats(0, 0);

    // Recovery after the dropped packet.
    txq = '{8'hC3, 8'h00, 8'h00};
    pq.push_back('{1'b1, 3'b000, 4'h3, 1'b1, 11'd0});
    send(-1);
    check_stats(1, 0);

    check("dq_empty", 32'(dq.size()), 32'(0));
    check("pq_empty", 32'(pq.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
